// File: rtl/lrf_axis_frame_rx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lrf_axis_frame_rx
//
// AXI4-Stream slave front end for the LRF fusion datapath. Accepts the
// interleaved old/new frame-pair stream (N_PAIRS pairs), tags each beat with
// frame phase, row, word column and frame/line boundary markers, buffers the
// tagged beats in a 2-entry FIFO and presents them to the convolution core.
// Also checks that tlast lands on the final beat of the stream.
//
// Ports:
//   s_axis_aclk, s_axis_aresetn  clock, async active-low reset
//   s_axis_tdata/tvalid/tlast    input stream; s_axis_tready back-pressure
//   m_tdata/m_tvalid/m_tready    tagged word to the core (valid/ready)
//   m_phase                      0 = old frame, 1 = new frame
//   m_row, m_col                 line index, word index within the line
//   m_sof, m_eol, m_eof, m_last  frame start, line end, frame end, stream end
//   stream_done                  sticky, final beat accepted
//   err_early_last               sticky, tlast seen on a non-final beat
//   err_missing_last             sticky, final beat arrived without tlast
// -----------------------------------------------------------------------------
module lrf_axis_frame_rx #(
    parameter int WORD_WIDTH   = 128,
    parameter int PIXEL_WIDTH  = 8,
    parameter int IMAGE_WIDTH  = 512,
    parameter int IMAGE_HEIGHT = 512,
    parameter int N_PAIRS      = 2,
    localparam int PPW    = WORD_WIDTH / PIXEL_WIDTH,
    localparam int WPL    = IMAGE_WIDTH / PPW,
    localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1,
    localparam int COL_W  = (WPL > 1) ? $clog2(WPL) : 1,
    localparam int PAIR_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1
) (
    input  logic                  s_axis_aclk,
    input  logic                  s_axis_aresetn,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [WORD_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_phase,
    output logic [ROW_W-1:0]      m_row,
    output logic [COL_W-1:0]      m_col,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  m_last,
    output logic                  stream_done,
    output logic                  err_early_last,
    output logic                  err_missing_last
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    typedef struct packed {
        logic                  last;
        logic                  eof;
        logic                  eol;
        logic                  sof;
        logic [COL_W-1:0]      col;
        logic [ROW_W-1:0]      row;
        logic                  phase;
        logic [WORD_WIDTH-1:0] data;
    } entry_t;

    // Position counters
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              phase_q, phase_d;
    logic [PAIR_W-1:0] pair_q, pair_d;

    // FIFO
    entry_t     mem [2];
    entry_t     wr_entry;
    entry_t     head;
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] occ_q, occ_d;

    // Control
    state_t state_q, state_d;
    logic   armed_q;        // holds tready low until the first edge after reset
    logic   err_early_q, err_missing_q;

    logic acc, pop;
    logic at_sof, at_eol, at_eof, at_fin;

    assign acc = s_axis_tvalid & s_axis_tready;
    assign pop = m_tvalid & m_tready;

    // Tags describe the beat being accepted, i.e. the pre-increment position.
    assign at_sof = (row_q == '0) && (col_q == '0);
    assign at_eol = (col_q == COL_W'(WPL - 1));
    assign at_eof = at_eol && (row_q == ROW_W'(IMAGE_HEIGHT - 1));
    assign at_fin = at_eof && phase_q && (pair_q == PAIR_W'(N_PAIRS - 1));

    // Ready is a pure function of registers so the upstream never sees a
    // combinational path from its own tvalid.
    assign s_axis_tready = armed_q && (occ_q != 2'd2) && (state_q == ST_RUN);

    // -------------------------------------------------------------------------
    // Counter advance. An early tlast resynchronises to the start of the stream
    // so the core's view of position recovers from a short upstream frame.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output is defaulted before any branch so
        // no path leaves it unassigned and no latch is inferred.
        col_d   = col_q;
        row_d   = row_q;
        phase_d = phase_q;
        pair_d  = pair_q;
        if (acc) begin
            if (s_axis_tlast && !at_fin) begin
                col_d   = '0;
                row_d   = '0;
                phase_d = 1'b0;
                pair_d  = '0;
            end else if (at_eol) begin
                col_d = '0;
                if (at_eof) begin
                    row_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        pair_d = pair_q + 1'b1;
                    end
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Next state: DONE is left only through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (acc && at_fin) state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
        endcase
    end

    always_comb begin
        occ_d = occ_q;
        case ({acc, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_comb begin
        wr_entry.data  = s_axis_tdata;
        wr_entry.phase = phase_q;
        wr_entry.row   = row_q;
        wr_entry.col   = col_q;
        wr_entry.sof   = at_sof;
        wr_entry.eol   = at_eol;
        wr_entry.eof   = at_eof;
        // Either tlast or the final position ends the stream for the core.
        wr_entry.last  = at_fin | s_axis_tlast;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            col_q         <= '0;
            row_q         <= '0;
            phase_q       <= 1'b0;
            pair_q        <= '0;
            state_q       <= ST_RUN;
            armed_q       <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            occ_q         <= '0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            // NOTE: the storage is reset too because the head entry drives the
            // outputs directly and they must read 0 while in reset; at two
            // entries this costs nothing worth avoiding.
            mem[0]        <= '0;
            mem[1]        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the values from before this edge regardless of order.
            col_q   <= col_d;
            row_q   <= row_d;
            phase_q <= phase_d;
            pair_q  <= pair_d;
            state_q <= state_d;
            armed_q <= 1'b1;
            occ_q   <= occ_d;
            if (acc && s_axis_tlast && !at_fin) begin
                err_early_q <= 1'b1;
            end
            if (acc && at_fin && !s_axis_tlast) begin
                err_missing_q <= 1'b1;
            end
            if (acc) begin
                mem[wr_ptr_q] <= wr_entry;
                wr_ptr_q      <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: the head entry is held until popped, so it is stable under
    // back-pressure.
    // -------------------------------------------------------------------------
    assign head             = mem[rd_ptr_q];
    assign m_tvalid         = (occ_q != 2'd0);
    assign m_tdata          = head.data;
    assign m_phase          = head.phase;
    assign m_row            = head.row;
    assign m_col            = head.col;
    assign m_sof            = head.sof;
    assign m_eol            = head.eol;
    assign m_eof            = head.eof;
    assign m_last           = head.last;
    assign stream_done      = (state_q == ST_DONE);
    assign err_early_last   = err_early_q;
    assign err_missing_last = err_missing_q;

endmodule

// File: doc/lrf_axis_frame_rx.md
# lrf_axis_frame_rx

AXI4-Stream slave front end for the LRF fusion datapath. It accepts the interleaved frame-pair stream of 128-bit words (each word is 16 packed 8-bit pixels): an old frame, then a new frame, repeated for N_PAIRS pairs. It tags every beat with frame phase, row, word-column and frame/line boundary markers, and buffers the beats in a 2-entry FIFO. It presents them to the convolution core over a valid/ready port, and checks that tlast falls on the correct beat.

## Interface
- WORD_WIDTH, 128, stream data width
- PIXEL_WIDTH, 8, pixel width; PPW = WORD_WIDTH/PIXEL_WIDTH = 16
- IMAGE_WIDTH, 512, pixels per line; WPL = IMAGE_WIDTH/PPW = 32 words per line
- IMAGE_HEIGHT, 512, lines per frame; BPF = WPL*IMAGE_HEIGHT = 16384 beats per frame
- N_PAIRS, 2, number of old/new frame pairs per stream
- s_axis_aclk  in  1  clock
- s_axis_aresetn  in  1  reset; one clock; asynchronous, active-low
- s_axis_tdata  in  WORD_WIDTH  input word, pixel j at bits [j*8 +: 8]
- s_axis_tvalid  in  1  input valid
- s_axis_tlast  in  1  end of whole stream
- s_axis_tready  out  1  input ready
- m_tdata  out  WORD_WIDTH  word to core, bit-identical to input
- m_tvalid  out  1  output valid
- m_tready  in  1  core ready
- m_phase  out  1  0 = old frame, 1 = new frame
- m_row  out  clog2(IMAGE_HEIGHT)  line index
- m_col  out  clog2(WPL)  word index within line
- m_sof  out  1  first beat of a frame
- m_eol  out  1  last beat of a line
- m_eof  out  1  last beat of a frame
- m_last  out  1  last beat of the stream
- stream_done  out  1  sticky; final beat accepted
- err_early_last  out  1  sticky; tlast on a non-final beat
- err_missing_last  out  1  sticky; final beat arrived without tlast

## Operation
- Input handshake: acc = s_axis_tvalid & s_axis_tready. Output handshake: pop = m_tvalid & m_tready.
- The position counters col, row, phase and pair advance only on acc. They are held unchanged at all other times.
- The tags of the accepted beat come from the counters before the increment:
  - sof = (row==0 & col==0)
  - eol = (col==WPL-1)
  - eof = eol & (row==IMAGE_HEIGHT-1)
  - fin = eof & phase & (pair==N_PAIRS-1)
  - m_last = fin
- Counter advance on acc:
  - col increments and wraps at WPL-1. On wrap, row increments.
  - row wraps at IMAGE_HEIGHT-1. On wrap, phase toggles.
  - pair increments when phase goes from 1 to 0.
- FIFO: 2 entries, each holding {tdata, tags}. occ is 0..2.
  - acc & !pop: occ+1
  - pop & !acc: occ-1
  - both: occ unchanged
  - Read order is FIFO. The head entry drives the m_* outputs.
- s_axis_tready = (occ<2) & !stream_done. It depends only on registers, never on s_axis_tvalid.
- m_tvalid = (occ!=0). Head data and tags stay stable while m_tvalid & !m_tready.
- FSM, states RUN and DONE:
  - RUN goes to DONE on acc of a fin beat.
  - DONE: stream_done=1 and s_axis_tready=0. The FIFO still drains to the core. DONE exits only on reset.
- tlast checking:
  - acc & s_axis_tlast & !fin: set err_early_last. Enqueue the beat with m_last=1. Clear col, row, phase and pair to 0 in the same cycle (resync). Stay in RUN.
  - acc & fin & !s_axis_tlast: set err_missing_last. Still enqueue with m_last=1 and enter DONE.
  - Both error flags are sticky until reset.

## Timing
- Reset (async assert; deassert sampled on s_axis_aclk): all of the following go to 0:
  - m_tvalid, m_tdata, all tags, occ, counters
  - stream_done, both error flags
  - s_axis_tready (it reads 1 from the first clock edge after reset deassert)
- Reset in the middle of a stream discards FIFO contents and restarts at pair 0, old frame, row 0, col 0.
- Latency: a beat accepted at edge k is visible on m_* after edge k (1 cycle).
- Throughput: 1 beat/cycle while m_tready=1 and s_axis_tvalid=1, with occ steady at 1.
- Backpressure: m_tready=0 for 2 cycles fills the FIFO (occ=2), and s_axis_tready drops in the following cycle. No beat is lost or duplicated.
- Full FIFO with simultaneous pop: s_axis_tready is 0 in that cycle. A beat is accepted in the next cycle.

## Test plan
- Full stream (N_PAIRS=2, 65536 beats, random valid/ready, ramp data):
  - every output word equals its input word, in order
  - m_sof count = 4, m_eof count = 4
  - m_phase sequence per frame = 0,1,0,1
  - m_last only on beat 65535
  - stream_done=1 and both error flags = 0
- Beat 31 with tvalid and ready held high: m_eol=1, m_col=31, m_row=0. Beat 32: m_col=0, m_row=1, m_eol=0.
- m_tready=0 for 10 cycles with s_axis_tvalid=1: occ saturates at 2 and s_axis_tready=0 after 2 accepts. On release, the output is the next two words in order, then streaming at 1 beat/cycle.
- tlast on beat 100: err_early_last=1, that output has m_last=1, and the next beat emerges with m_sof=1, m_phase=0, m_row=0, m_col=0.
- Final beat (beat 65535) with tlast=0: err_missing_last=1, m_last=1, stream_done=1, s_axis_tready stays 0.
- aresetn pulsed low mid-frame (row 200) with occ=2: all outputs 0 immediately. After release, the first accepted beat has m_sof=1 and m_phase=0.
